vga_timing_ctrl: RTL

//  Sequences the horizontal/vertical pixel counters that drive the VGA output side of the
//  NES-to-VGA converter. Walks each axis through ACTIVE/FRONT/SYNC/BACK states and emits

---
 rtl/vga_timing_ctrl.sv | 134 +++++++++++++
 1 files changed

// File: rtl/vga_timing_ctrl.sv
// VGA raster timing generator: horizontal and vertical counters, each walked
// through ACTIVE / FRONT PORCH / SYNC / BACK PORCH, with registered syncs,
// display enable and line/frame strobes all launched on the same edge.
module vga_timing_ctrl #(
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter int CW       = 10
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          pix_ce,
  input  logic          en,
  output logic [CW-1:0] hcnt,
  output logic [CW-1:0] vcnt,
  output logic          hsync_n,
  output logic          vsync_n,
  output logic          active,
  output logic          line_start,
  output logic          frame_start
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  // Last count value of each region; a state leaves its region on these.
  localparam logic [CW-1:0] H_ACT_LAST  = CW'(H_ACTIVE - 1);
  localparam logic [CW-1:0] H_FP_LAST   = CW'(H_ACTIVE + H_FP - 1);
  localparam logic [CW-1:0] H_SYNC_LAST = CW'(H_ACTIVE + H_FP + H_SYNC - 1);
  localparam logic [CW-1:0] H_LAST      = CW'(H_TOTAL - 1);
  localparam logic [CW-1:0] V_ACT_LAST  = CW'(V_ACTIVE - 1);
  localparam logic [CW-1:0] V_FP_LAST   = CW'(V_ACTIVE + V_FP - 1);
  localparam logic [CW-1:0] V_SYNC_LAST = CW'(V_ACTIVE + V_FP + V_SYNC - 1);
  localparam logic [CW-1:0] V_LAST      = CW'(V_TOTAL - 1);

  // One-hot so that a corrupted state register is detectable and recoverable.
  typedef enum logic [3:0] {
    ST_ACT  = 4'b0001,
    ST_FP   = 4'b0010,
    ST_SYNC = 4'b0100,
    ST_BP   = 4'b1000
  } axis_state_t;

  axis_state_t   h_state, h_state_next;
  axis_state_t   v_state, v_state_next;
  logic [CW-1:0] hcnt_next, vcnt_next;
  logic          adv;
  logic          line_end;
  logic          frame_end;
  logic          line_start_next;
  logic          frame_start_next;

  assign adv       = en & pix_ce;
  assign line_end  = (hcnt == H_LAST);
  assign frame_end = line_end & (vcnt == V_LAST);

  // Horizontal next state: counter steps every advance, state follows boundaries.
  always_comb begin
    h_state_next = h_state;
    hcnt_next    = hcnt;
    if (adv) begin
      hcnt_next = line_end ? '0 : hcnt + 1'b1;
      case (h_state)
        ST_ACT:  if (hcnt == H_ACT_LAST)  h_state_next = ST_FP;
        ST_FP:   if (hcnt == H_FP_LAST)   h_state_next = ST_SYNC;
        ST_SYNC: if (hcnt == H_SYNC_LAST) h_state_next = ST_BP;
        ST_BP:   if (line_end)            h_state_next = ST_ACT;
        default: begin
          h_state_next = ST_ACT;
          hcnt_next    = '0;
        end
      endcase
      // End of line always restarts in ACT so state and counter never disagree.
      if (line_end) h_state_next = ST_ACT;
    end
  end

  // Vertical next state: steps once per line, recovers from a bad state on any advance.
  always_comb begin
    v_state_next = v_state;
    vcnt_next    = vcnt;
    if (adv) begin
      if (line_end) vcnt_next = frame_end ? '0 : vcnt + 1'b1;
      case (v_state)
        ST_ACT:  if (line_end && vcnt == V_ACT_LAST)  v_state_next = ST_FP;
        ST_FP:   if (line_end && vcnt == V_FP_LAST)   v_state_next = ST_SYNC;
        ST_SYNC: if (line_end && vcnt == V_SYNC_LAST) v_state_next = ST_BP;
        ST_BP:   if (frame_end)                       v_state_next = ST_ACT;
        default: begin
          v_state_next = ST_ACT;
          vcnt_next    = '0;
        end
      endcase
      if (frame_end) v_state_next = ST_ACT;
    end
  end

  // Strobes mark the advance that wraps the horizontal (and vertical) counter.
  always_comb begin
    line_start_next  = adv & line_end;
    frame_start_next = adv & frame_end;
  end

  // State, counters and all outputs register together so they carry no skew.
  always_ff @(posedge clk) begin
    if (reset) begin
      h_state     <= ST_ACT;
      v_state     <= ST_ACT;
      hcnt        <= '0;
      vcnt        <= '0;
      hsync_n     <= 1'b1;
      vsync_n     <= 1'b1;
      active      <= 1'b1;
      line_start  <= 1'b0;
      frame_start <= 1'b0;
    end else begin
      h_state     <= h_state_next;
      v_state     <= v_state_next;
      hcnt        <= hcnt_next;
      vcnt        <= vcnt_next;
      hsync_n     <= (h_state_next != ST_SYNC);
      vsync_n     <= (v_state_next != ST_SYNC);
      active      <= (h_state_next == ST_ACT) && (v_state_next == ST_ACT);
      line_start  <= line_start_next;
      frame_start <= frame_start_next;
    end
  end

endmodule
